// File: rtl/line_window_buffer.sv
// Line buffer plus KxK window generator: stores K-1 previous lines, emits valid-region windows.
// Latency: window registered one cycle after the accept that completes it.
// Backpressure: s_ready = ~m_valid | m_ready; a stalled window holds output and blocks input.
module line_window_buffer #(
  parameter int PIX_W = 24,
  parameter int K     = 3,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [PIX_W-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [K*K*PIX_W-1:0] m_window,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 frame_done
);

  localparam int NL    = K - 1;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LP_W  = (NL > 1) ? $clog2(NL) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
  localparam logic [LP_W-1:0]  LP_LAST   = LP_W'(NL - 1);

  // Line memories are not reset; rows 0..K-2 of every frame rewrite them before use.
  logic [PIX_W-1:0] line_mem [NL][IMG_W];
  logic [PIX_W-1:0] win_q    [K][K];
  logic [PIX_W-1:0] new_col  [K];

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [LP_W-1:0]  ptr_q, ptr_d;   // memory holding the oldest stored line
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             frame_done_q, frame_done_d;

  logic accept, eol, eof, emit;

  // Memory holding the line that is 'off' lines newer than the oldest one.
  function automatic logic [LP_W-1:0] line_sel(input logic [LP_W-1:0] base,
                                               input logic [LP_W-1:0] off);
    logic [LP_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= (LP_W+1)'(NL)) s = s - (LP_W+1)'(NL);
    return s[LP_W-1:0];
  endfunction

  assign s_ready    = ~m_valid_q | m_ready;
  assign accept     = s_valid & s_ready;
  assign eol        = (col_q == COL_LAST);
  assign eof        = eol & (row_q == ROW_LAST);
  assign emit       = accept & (row_q >= ROW_FIRST) & (col_q >= COL_FIRST);
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;

  // New rightmost window column: stored lines oldest->newest, then the incoming pixel.
  always_comb begin
    for (int r = 0; r < NL; r++) begin
      new_col[r] = line_mem[line_sel(ptr_q, LP_W'(r))][col_q];
    end
    new_col[K-1] = s_data;
  end

  // Raster counters; the line pointer rotates at every end of line.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ptr_d = ptr_q;
    if (accept) begin
      if (eol) begin
        col_d = '0;
        row_d = eof ? '0 : row_q + 1'b1;
        ptr_d = (ptr_q == LP_LAST) ? '0 : ptr_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Output stage: load on a completed window, clear once consumed, otherwise hold.
  always_comb begin
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    frame_done_d = accept & eof;
    if (emit) begin
      m_valid_d = 1'b1;
      m_last_d  = eof;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q        <= '0;
      row_q        <= '0;
      ptr_q        <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ptr_q        <= ptr_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window shift array: shift left on accept, new column enters at c=K-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][K-1] <= new_col[r];
      end
    end
  end

  // Overwrite the oldest line after its pixel has been read into the window.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[ptr_q][col_q] <= s_data;
    end
  end

  // Flatten the window; row 0 is the oldest line, column 0 the leftmost pixel.
  always_comb begin
    m_window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        m_window[PIX_W*(r*K+c) +: PIX_W] = win_q[r][c];
      end
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
module tb_line_window_buffer;
  localparam int PW = 8, KA = 3, WA = 4, HA = 4, WWA = KA*KA*PW;
  localparam int PB = 24, KB = 5, WB = 8, HB = 6, WWB = KB*KB*PB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn;
  logic [PW-1:0]  s_data;
  logic           s_valid, s_ready;
  logic [WWA-1:0] m_window;
  logic           m_valid, m_ready, m_last, frame_done;

  logic [PB-1:0]  b_s_data;
  logic           b_s_valid, b_s_ready;
  logic [WWB-1:0] b_m_window;
  logic           b_m_valid, b_m_ready, b_m_last, b_frame_done;

  line_window_buffer #(.PIX_W(PW), .K(KA), .IMG_W(WA), .IMG_H(HA)) dut_a (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_window(m_window), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_done(frame_done));

  line_window_buffer #(.PIX_W(PB), .K(KB), .IMG_W(WB), .IMG_H(HB)) dut_b (
    .clk(clk), .resetn(resetn), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_window(b_m_window), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .frame_done(b_frame_done));

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stall 5 cycles on first window, 3 never ready

  logic [PW-1:0]  img_a [HA][WA];
  logic [PB-1:0]  img_b [HB][WB];
  logic [WWA-1:0] exp_win[$];
  logic           exp_last[$];
  logic [WWA-1:0] got_win[$];
  logic           got_last[$];
  logic [WWB-1:0] got_b[$];
  logic           got_b_last[$];
  int fd_cnt = 0;
  int fd_b = 0;

  // Downstream ready generator.
  initial begin : rdy_drv
    int stalls;
    stalls = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) begin
        if (m_valid && stalls < 5) begin m_ready = 1'b0; stalls++; end
        else m_ready = 1'b1;
      end else begin
        stalls = 0;
        if (rdy_mode == 1) m_ready = ($urandom_range(1) == 1);
        else if (rdy_mode == 3) m_ready = 1'b0;
        else m_ready = 1'b1;
      end
    end
  end

  // Transfer monitor: a window is consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (m_valid && m_ready) begin got_win.push_back(m_window); got_last.push_back(m_last); end
    if (frame_done) fd_cnt++;
    if (b_m_valid && b_m_ready) begin got_b.push_back(b_m_window); got_b_last.push_back(b_m_last); end
    if (b_frame_done) fd_b++;
  end

  // Reference model: every KxK neighbourhood fully inside the frame, raster order.
  task automatic model_a();
    logic [WWA-1:0] w;
    for (int r = KA-1; r < HA; r++)
      for (int c = KA-1; c < WA; c++) begin
        w = '0;
        for (int i = 0; i < KA; i++)
          for (int j = 0; j < KA; j++)
            w[PW*(i*KA+j) +: PW] = img_a[r-(KA-1)+i][c-(KA-1)+j];
        exp_win.push_back(w);
        exp_last.push_back(r == HA-1 && c == WA-1);
      end
  endtask

  task automatic fill_a(input int base);
    for (int r = 0; r < HA; r++)
      for (int c = 0; c < WA; c++)
        img_a[r][c] = PW'(base + 16*r + c);
  endtask

  task automatic push_a(input logic [PW-1:0] v, input int vprob);
    int  guard;
    bit  done;
    guard = 0;
    done = 0;
    while (!done) begin
      s_data  = v;
      s_valid = ($urandom_range(99) < vprob);
      @(negedge clk);
      done = s_valid && s_ready;
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 500) begin
        checks++; errors++;
        $display("FAIL push_a_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, guard);
        done = 1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame_a(input int vprob);
    for (int r = 0; r < HA; r++)
      for (int c = 0; c < WA; c++)
        push_a(img_a[r][c], vprob);
  endtask

  task automatic drain_a();
    int k;
    k = 0;
    while (m_valid && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL drain_a: m_valid=%0b, required 0", m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b, required 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %0b, required 0", m_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %0b, required 0", frame_done); end
    checks++; if (m_window !== '0) begin errors++; $display("FAIL rst_m_window: got %h, required 0", m_window); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %0b, required 1", s_ready); end
    checks++; if (b_m_valid !== 1'b0) begin errors++; $display("FAIL rst_b_m_valid: got %0b, required 0", b_m_valid); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int eb, gb, fd0, delta;
    logic [WWA-1:0] w1;
    int first, acc11;
    w1 = 72'h222120121110020100;
    rdy_mode = 0;
    fill_a(0);
    eb = exp_win.size(); gb = got_win.size(); fd0 = fd_cnt;
    model_a();
    first = -1; acc11 = -1;
    fork
      send_frame_a(100);
      begin
        int acc;
        acc = 0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (m_valid && first < 0) first = k;
          if (s_valid && s_ready) begin acc++; if (acc == 11) acc11 = k; end
        end
      end
    join
    drain_a();
    checks++;
    if (first - acc11 !== 1 || acc11 < 0) begin
      errors++; $display("FAIL stream_latency: first m_valid at cycle %0d, 11th accept at %0d, required one cycle later", first, acc11);
    end
    delta = got_win.size() - gb;
    checks++; if (delta !== 4) begin errors++; $display("FAIL stream_count: got %0d windows, required 4", delta); end
    for (int i = 0; i < 4; i++) if (gb + i < got_win.size()) begin
      checks++;
      if (got_win[gb+i] !== exp_win[eb+i] || got_last[gb+i] !== exp_last[eb+i]) begin
        errors++; $display("FAIL stream_win%0d: got %h last=%0b, required %h last=%0b", i, got_win[gb+i], got_last[gb+i], exp_win[eb+i], exp_last[eb+i]);
      end
    end
    if (delta >= 4) begin
      checks++; if (got_win[gb] !== w1) begin errors++; $display("FAIL stream_first: got %h, required %h", got_win[gb], w1); end
      checks++; if (got_win[gb+3][PW*4 +: PW] !== 8'h22 || got_last[gb+3] !== 1'b1) begin
        errors++; $display("FAIL stream_fourth: centre %h last=%0b, required 22 last=1", got_win[gb+3][PW*4 +: PW], got_last[gb+3]);
      end
    end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL stream_frame_done: got %0d pulses, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_backpressure();
    int eb, gb, delta;
    rdy_mode = 2;
    fill_a(0);
    eb = exp_win.size(); gb = got_win.size();
    model_a();
    fork
      send_frame_a(100);
      begin
        int k;
        logic [WWA-1:0] w0;
        k = 0;
        while (!m_valid && k < 100) begin @(negedge clk); k++; end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_wait: m_valid=%0b, required 1", m_valid); end
        w0 = m_window;
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_window !== w0) begin
            errors++; $display("FAIL bp_hold%0d: s_ready=%0b m_valid=%0b win=%h, required 0 1 %h", i, s_ready, m_valid, m_window, w0);
          end
          @(negedge clk);
        end
      end
    join
    drain_a();
    rdy_mode = 0;
    delta = got_win.size() - gb;
    checks++; if (delta !== 4) begin errors++; $display("FAIL bp_count: got %0d windows, required 4", delta); end
    for (int i = 0; i < 4; i++) if (gb + i < got_win.size()) begin
      checks++;
      if (got_win[gb+i] !== exp_win[eb+i] || got_last[gb+i] !== exp_last[eb+i]) begin
        errors++; $display("FAIL bp_win%0d: got %h last=%0b, required %h last=%0b", i, got_win[gb+i], got_last[gb+i], exp_win[eb+i], exp_last[eb+i]);
      end
    end
  endtask

  task automatic test_random();
    int eb, gb, fd0, delta;
    rdy_mode = 1;
    eb = exp_win.size(); gb = got_win.size(); fd0 = fd_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < HA; r++)
        for (int c = 0; c < WA; c++)
          img_a[r][c] = PW'($urandom_range(255));
      model_a();
      send_frame_a(50);
    end
    drain_a();
    rdy_mode = 0;
    delta = got_win.size() - gb;
    checks++; if (delta !== 12) begin errors++; $display("FAIL rand_count: got %0d windows, required 12", delta); end
    for (int i = 0; i < 12; i++) if (gb + i < got_win.size()) begin
      checks++;
      if (got_win[gb+i] !== exp_win[eb+i] || got_last[gb+i] !== ((i % 4) == 3)) begin
        errors++; $display("FAIL rand_win%0d: got %h last=%0b, required %h last=%0b", i, got_win[gb+i], got_last[gb+i], exp_win[eb+i], ((i % 4) == 3));
      end
    end
    checks++; if (fd_cnt - fd0 !== 3) begin errors++; $display("FAIL rand_frame_done: got %0d pulses, required 3", fd_cnt - fd0); end
  endtask

  task automatic test_reset_midframe();
    int eb, gb, fd0, delta;
    rdy_mode = 3;
    for (int r = 0; r < HA; r++)
      for (int c = 0; c < WA; c++)
        img_a[r][c] = PW'(8'hE0 + 4*r + c);
    for (int n = 0; n < 11; n++) push_a(img_a[n / WA][n % WA], 100);
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_pending: m_valid=%0b s_ready=%0b, required 1 0", m_valid, s_ready);
    end
    #2 resetn = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_window !== '0) begin
      errors++; $display("FAIL rmid_async: m_valid=%0b m_last=%0b win=%h, required 0 0 0", m_valid, m_last, m_window);
    end
    @(negedge clk);
    resetn = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    fill_a(0);
    eb = exp_win.size(); gb = got_win.size(); fd0 = fd_cnt;
    model_a();
    send_frame_a(100);
    drain_a();
    delta = got_win.size() - gb;
    checks++; if (delta !== 4) begin errors++; $display("FAIL rmid_count: got %0d windows, required 4", delta); end
    for (int i = 0; i < 4; i++) if (gb + i < got_win.size()) begin
      checks++;
      if (got_win[gb+i] !== exp_win[eb+i] || got_last[gb+i] !== exp_last[eb+i]) begin
        errors++; $display("FAIL rmid_win%0d: got %h, required %h", i, got_win[gb+i], exp_win[eb+i]);
      end
    end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL rmid_frame_done: got %0d pulses, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_back_to_back();
    int eb, gb, fd0, delta;
    logic [WWA-1:0] wb1;
    wb1 = 72'hA2A1A0929190828180;
    rdy_mode = 0;
    eb = exp_win.size(); gb = got_win.size(); fd0 = fd_cnt;
    fill_a(0);    model_a(); send_frame_a(100);
    fill_a(8'h80); model_a(); send_frame_a(100);
    drain_a();
    delta = got_win.size() - gb;
    checks++; if (delta !== 8) begin errors++; $display("FAIL b2b_count: got %0d windows, required 8", delta); end
    for (int i = 0; i < 8; i++) if (gb + i < got_win.size()) begin
      checks++;
      if (got_win[gb+i] !== exp_win[eb+i] || got_last[gb+i] !== exp_last[eb+i]) begin
        errors++; $display("FAIL b2b_win%0d: got %h last=%0b, required %h last=%0b", i, got_win[gb+i], got_last[gb+i], exp_win[eb+i], exp_last[eb+i]);
      end
    end
    if (delta >= 5) begin
      checks++; if (got_win[gb+4] !== wb1) begin errors++; $display("FAIL b2b_first_b: got %h, required %h", got_win[gb+4], wb1); end
    end
    checks++; if (fd_cnt - fd0 !== 2) begin errors++; $display("FAIL b2b_frame_done: got %0d pulses, required 2", fd_cnt - fd0); end
  endtask

  task automatic test_param_sweep();
    int gb, fd0, delta, n;
    logic [WWB-1:0] ew[$];
    logic           el[$];
    logic [WWB-1:0] w;
    localparam int CTR = PB*((KB-1)/2*KB + (KB-1)/2);
    for (int r = 0; r < HB; r++)
      for (int c = 0; c < WB; c++)
        img_b[r][c] = PB'($urandom);
    for (int r = KB-1; r < HB; r++)
      for (int c = KB-1; c < WB; c++) begin
        w = '0;
        for (int i = 0; i < KB; i++)
          for (int j = 0; j < KB; j++)
            w[PB*(i*KB+j) +: PB] = img_b[r-(KB-1)+i][c-(KB-1)+j];
        ew.push_back(w);
        el.push_back(r == HB-1 && c == WB-1);
      end
    gb = got_b.size(); fd0 = fd_b;
    for (int r = 0; r < HB; r++)
      for (int c = 0; c < WB; c++) begin
        int guard;
        guard = 0;
        b_s_data = img_b[r][c];
        b_s_valid = 1'b1;
        @(negedge clk);
        while (!b_s_ready && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
      end
    b_s_valid = 1'b0;
    repeat (6) @(negedge clk);
    delta = got_b.size() - gb;
    checks++; if (delta !== 8) begin errors++; $display("FAIL sweep_count: got %0d windows, required 8", delta); end
    n = (delta < 8) ? delta : 8;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_b[gb+i] !== ew[i] || got_b_last[gb+i] !== el[i]) begin
        errors++; $display("FAIL sweep_win%0d: centre %h last=%0b, required centre %h last=%0b", i, got_b[gb+i][CTR +: PB], got_b_last[gb+i], ew[i][CTR +: PB], el[i]);
      end
    end
    if (delta >= 8) begin
      checks++; if (got_b[gb][CTR +: PB] !== img_b[2][2]) begin errors++; $display("FAIL sweep_first_centre: got %h, required %h", got_b[gb][CTR +: PB], img_b[2][2]); end
      checks++; if (got_b[gb+7][CTR +: PB] !== img_b[3][5]) begin errors++; $display("FAIL sweep_last_centre: got %h, required %h", got_b[gb+7][CTR +: PB], img_b[3][5]); end
    end
    checks++; if (fd_b - fd0 !== 1) begin errors++; $display("FAIL sweep_frame_done: got %0d pulses, required 1", fd_b - fd0); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_midframe();
    test_back_to_back();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
